// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and baud divider helper.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } rx_state_e;

    // Clock cycles per oversample tick (integer truncation).
    function automatic int unsigned uart_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned os);
        return clk_freq / (baud * os);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running divider producing a one-clock tick every DIV clocks.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   tick - registered one-cycle pulse every DIV cycles
module uart_tick_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = ($clog2(DIV + 1) < 1) ? 1 : $clog2(DIV + 1);

    if (DIV < 1) begin : g_bad_div
        $error("uart_tick_gen: DIV must be at least 1");
    end

    logic [CW-1:0] cnt;

    // Counter wraps at DIV-1; tick is registered alongside the wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: 8N1 (optional parity) with mid-bit sampling,
// false-start rejection, stop-bit check and a one-entry valid/ready holding register.
// Optional feature macro: UART_RX_PARITY_EN (adds PARITY_ODD parameter and parity check).
// Ports:
//   clk         - system clock
//   rst         - asynchronous active-low reset
//   rx          - asynchronous serial input, idle high
//   rx_ready    - consumer accepts held byte while rx_valid is high
//   rx_data     - received byte, stable while rx_valid is high
//   rx_valid    - holding register full
//   frame_err   - one-cycle pulse, stop bit sampled low
//   overrun_err - one-cycle pulse, byte completed while holding register full
//   parity_err  - one-cycle pulse, parity mismatch (always 0 without parity)
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 1000000,
    parameter int unsigned BAUD_RATE  = 9600,
`ifdef UART_RX_PARITY_EN
    parameter bit          PARITY_ODD = 1'b0,
`endif
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    input  logic                      rx_ready,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      frame_err,
    output logic                      overrun_err,
    output logic                      parity_err
);

    localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned TW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = 3;
    localparam int unsigned DW  = UART_DATA_BITS;

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_oversample: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
        $error("uart_rx_oversample: OVERSAMPLE must be even and >= 4");
    end

    localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

    logic tick;

    uart_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchronizer plus previous value for falling-edge detection.
    logic rx_s1, rx_s2, rx_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    rx_state_e     state, state_d;
    logic [TW-1:0] tcnt, tcnt_d;
    logic [BW-1:0] bcnt, bcnt_d;
    logic [DW-1:0] shift, shift_d;
    logic [DW-1:0] data_d;
    logic          valid_d;
    logic          ferr_d, ovr_d, perr_d;
    logic          deliver_c;
    logic          par_bad_c;

`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_d;
    assign par_bad_c = par_bad;
`else
    assign par_bad_c = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tcnt        <= '0;
            bcnt        <= '0;
            shift       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            parity_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad     <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            tcnt        <= tcnt_d;
            bcnt        <= bcnt_d;
            shift       <= shift_d;
            rx_data     <= data_d;
            rx_valid    <= valid_d;
            frame_err   <= ferr_d;
            overrun_err <= ovr_d;
            parity_err  <= perr_d;
`ifdef UART_RX_PARITY_EN
            par_bad     <= par_bad_d;
`endif
        end
    end

    // Next-state, bit sampling and holding-register control.
    always_comb begin
        state_d   = state;
        tcnt_d    = tcnt;
        bcnt_d    = bcnt;
        shift_d   = shift;
        data_d    = rx_data;
        valid_d   = rx_valid;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        perr_d    = 1'b0;
        deliver_c = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad;
`endif

        case (state)
            IDLE: begin
                if (rx_prev && !rx_s2) begin
                    tcnt_d  = '0;
                    state_d = START;
                end
            end

            START: begin
                if (tick) begin
                    if (tcnt == HALF_TICK) begin
                        tcnt_d = '0;
                        if (rx_s2) begin
                            state_d = IDLE;
                        end else begin
                            bcnt_d  = '0;
                            state_d = DATA;
                        end
                    end else begin
                        tcnt_d = tcnt + TW'(1);
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (tcnt == LAST_TICK) begin
                        tcnt_d  = '0;
                        shift_d = {rx_s2, shift[DW-1:1]};
                        bcnt_d  = bcnt + BW'(1);
                        if (bcnt == BW'(DW - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        tcnt_d = tcnt + TW'(1);
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (tcnt == LAST_TICK) begin
                        tcnt_d    = '0;
                        par_bad_d = ((^shift) ^ rx_s2) != PARITY_ODD;
                        state_d   = STOP;
                    end else begin
                        tcnt_d = tcnt + TW'(1);
                    end
                end
            end
`endif

            STOP: begin
                if (tick) begin
                    if (tcnt == LAST_TICK) begin
                        tcnt_d = '0;
                        perr_d = par_bad_c;
                        if (!rx_s2) begin
                            ferr_d  = 1'b1;
                            state_d = BREAK_WAIT;
                        end else begin
                            deliver_c = !par_bad_c;
                            state_d   = IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt + TW'(1);
                    end
                end
            end

            BREAK_WAIT: begin
                if (rx_s2) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A delivery coinciding with an accept reloads without overrun.
        if (deliver_c) begin
            if (!rx_valid || rx_ready) begin
                data_d  = shift_d;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (rx_valid && rx_ready) begin
            valid_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
module tb_uart_rx_oversample;

    localparam int unsigned CLK_FREQ = 16000000;
    localparam int unsigned BAUD     = 1000000;
    localparam int          OS       = 16;
`ifdef UART_RX_PARITY_EN
    localparam int          NB       = 11;
    localparam bit          PAR_EN   = 1'b1;
    localparam bit          P_ODD    = 1'b0;
`else
    localparam int          NB       = 10;
    localparam bit          PAR_EN   = 1'b0;
`endif
    // Start edge to rx_valid: sync delay, half start bit, remaining bit times, load clock.
    localparam int          LAT      = 2 + OS / 2 + (NB - 1) * OS + 1;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;

    uart_rx_oversample #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .OVERSAMPLE (OS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: holding register contents and cumulative pulse counts.
    bit         m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    int ferr_exp = 0, ovr_exp = 0, perr_exp = 0;
    int ferr_seen = 0, ovr_seen = 0, perr_seen = 0;

    always @(negedge clk) begin
        if (frame_err === 1'b1)   ferr_seen++;
        if (overrun_err === 1'b1) ovr_seen++;
        if (parity_err === 1'b1)  perr_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_totals(input string tag);
        check({tag, "_ferr_total"}, 32'(ferr_seen), 32'(ferr_exp));
        check({tag, "_ovr_total"},  32'(ovr_seen),  32'(ovr_exp));
        check({tag, "_perr_total"}, 32'(perr_seen), 32'(perr_exp));
    endtask

    // Drive one frame and check outputs at the cycles around the expected delivery.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                              input bit rdy, input int gap);
        logic [NB-1:0] bits;
        bit e_ferr, e_perr, e_ovr, deliver;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
        bits[9]   = (^d) ^ P_ODD ^ !par_ok;
`endif
        bits[NB-1] = stop_ok;
        e_ferr  = !stop_ok;
        e_perr  = PAR_EN && !par_ok;
        deliver = stop_ok && !e_perr;
        e_ovr   = 1'b0;
        for (int k = 0; k < NB * OS; k++) begin
            @(negedge clk);
            rx = bits[k / OS];
            if (k == 0) rx_ready = rdy;
            if (k == 1 && rdy) m_valid = 1'b0;
            if (k == LAT - 1) begin
                check("valid_pre", 32'(rx_valid), 32'(m_valid));
                check("pulses_pre", 32'({frame_err, overrun_err, parity_err}), 32'(0));
            end
            if (k == LAT) begin
                if (deliver) begin
                    if (!m_valid) begin
                        m_valid = 1'b1;
                        m_data  = d;
                    end else begin
                        e_ovr = 1'b1;
                    end
                end
                ferr_exp += int'(e_ferr);
                perr_exp += int'(e_perr);
                ovr_exp  += int'(e_ovr);
                check("valid_at_lat", 32'(rx_valid), 32'(m_valid));
                check("data_at_lat", 32'(rx_data), 32'(m_data));
                check("frame_err", 32'(frame_err), 32'(e_ferr));
                check("overrun_err", 32'(overrun_err), 32'(e_ovr));
                check("parity_err", 32'(parity_err), 32'(e_perr));
            end
            if (k == LAT + 1) begin
                if (rdy) m_valid = 1'b0;
                check("valid_post", 32'(rx_valid), 32'(m_valid));
                check("pulses_post", 32'({frame_err, overrun_err, parity_err}), 32'(0));
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] ff_bits;
        bit         sok, pok, rdy;
        rst      = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data", 32'(rx_data), 32'(0));
        check("reset_valid", 32'(rx_valid), 32'(0));
        check("reset_pulses", 32'({frame_err, overrun_err, parity_err}), 32'(0));
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Basic frame with exact latency.
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 4);

        // Short low glitch must be rejected as a false start.
        rx_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            rx = 1'b0;
        end
        repeat (30) begin
            @(negedge clk);
            rx = 1'b1;
        end
        check("glitch_valid", 32'(rx_valid), 32'(m_valid));
        check_totals("glitch");

        // Framing error then recovery.
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 5);
        send_frame(8'h81, 1'b1, 1'b1, 1'b1, 3);
        check_totals("frame");

        // Overrun with consumer stalled.
        send_frame(8'h11, 1'b1, 1'b1, 1'b0, 2);
        send_frame(8'h22, 1'b1, 1'b1, 1'b0, 2);
        check("overrun_keep_data", 32'(rx_data), 32'(8'h11));

        // Reset in the middle of data bit 4 of 0xFF.
        ff_bits = 8'hFF;
        for (int k = 0; k < OS * 5 + 8; k++) begin
            @(negedge clk);
            rx = (k < OS) ? 1'b0 : ff_bits[(k / OS - 1) % 8];
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset_outputs", 32'({rx_data, rx_valid, frame_err, overrun_err, parity_err}), 32'(0));
        repeat (3) @(negedge clk);
        rx = 1'b1;
        check("midreset_hold", 32'({rx_data, rx_valid, frame_err, overrun_err, parity_err}), 32'(0));
        @(negedge clk);
        rst     = 1'b1;
        m_valid = 1'b0;
        m_data  = 8'h00;
        repeat (5) @(negedge clk);
        check("after_reset_valid", 32'(rx_valid), 32'(0));
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 3);
        check_totals("reset");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 3);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 3);
        check_totals("parity");
`endif

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            rd  = 8'($urandom);
            sok = ($urandom_range(0, 9) != 0);
            pok = ($urandom_range(0, 4) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            send_frame(rd, sok, pok, rdy, sok ? int'($urandom_range(0, 12)) : int'($urandom_range(3, 12)));
        end
        repeat (4) @(negedge clk);
        check_totals("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
